// File: rtl/barrel_pkg.sv
// Barrel sprite shared definitions.
// Encodings and geometry also used by the colour lookup.
package barrel_pkg;

  localparam logic [2:0] BARREL_ROLL1 = 3'b000;
  localparam logic [2:0] BARREL_ROLL2 = 3'b001;
  localparam logic [2:0] BARREL_ROLL3 = 3'b010;
  localparam logic [2:0] BARREL_ROLL4 = 3'b011;
  localparam logic [2:0] BARREL_FALL1 = 3'b100;
  localparam logic [2:0] BARREL_FALL2 = 3'b101;

  localparam logic [9:0] ROLL_W    = 10'd32;
  localparam logic [9:0] FALL_W    = 10'd42;
  localparam logic [8:0] SPRITE_H  = 9'd24;
  localparam logic [9:0] FALL_XOFF = 10'd5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROLL,
    S_FALL,
    S_EXIT
  } state_t;

  typedef enum logic {
    DIR_RIGHT,
    DIR_LEFT
  } dir_t;

  function automatic logic [2:0] roll_next(
    input logic [2:0] f,
    input dir_t       d
  );
    logic [1:0] n;
    n = (d == DIR_RIGHT) ? f[1:0] + 2'd1
                         : f[1:0] - 2'd1;
    return {1'b0, n};
  endfunction

endpackage

// File: rtl/barrel_if.sv
// Game-logic side bundle for one barrel.
// master = game logic, slave = barrel_ctrl.
interface barrel_if;
  logic       frame_tick;
  logic       spawn;
  logic       hit;
  logic       pause;
  logic [9:0] posx;
  logic [8:0] posy;
  logic [2:0] animate_state;
  logic       active;
  logic       done;

  modport master (
    output frame_tick, spawn, hit, pause,
    input  posx, posy, animate_state,
    input  active, done
  );

  modport slave (
    input  frame_tick, spawn, hit, pause,
    output posx, posy, animate_state,
    output active, done
  );
endinterface

// File: rtl/barrel_anim_seq.sv
// Barrel animation frame sequencer.
// Divides steps by ANIM_DIV and walks the frame set.
module barrel_anim_seq
  import barrel_pkg::*;
#(
  parameter logic [3:0] ANIM_DIV = 4'd4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step,
  input  logic       mode_fall,
  input  dir_t       dir,
  input  logic       load,
  input  logic [2:0] load_frame,
  output logic [2:0] frame
);

  logic [3:0] anim_cnt;

  // Load overrides advance; advance on divider wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anim_cnt <= '0;
      frame    <= BARREL_ROLL1;
    end else if (load) begin
      anim_cnt <= '0;
      frame    <= load_frame;
    end else if (step) begin
      if (anim_cnt == ANIM_DIV - 4'd1) begin
        anim_cnt <= '0;
        if (mode_fall)
          frame <= (frame == BARREL_FALL1)
                   ? BARREL_FALL2 : BARREL_FALL1;
        else
          frame <= roll_next(frame, dir);
      end else begin
        anim_cnt <= anim_cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/barrel_ctrl.sv
// Barrel position FSM: roll, fall, reverse, exit.
// One instance per barrel, updated once per frame tick.
module barrel_ctrl
  import barrel_pkg::*;
#(
  parameter logic [9:0] START_X    = 10'd40,
  parameter logic [8:0] START_Y    = 9'd80,
  parameter logic [9:0] LEFT_EDGE  = 10'd16,
  parameter logic [9:0] RIGHT_EDGE = 10'd600,
  parameter logic [8:0] FLOOR_Y    = 9'd420,
  parameter logic [8:0] PLAT_PITCH = 9'd64,
  parameter logic [3:0] ROLL_SPEED = 4'd2,
  parameter logic [3:0] FALL_SPEED = 4'd4,
  parameter logic [3:0] ANIM_DIV   = 4'd4
) (
  input  logic     clk,
  input  logic     rst_n,
  barrel_if.slave  bus
);

  localparam logic [9:0] R_LIM = RIGHT_EDGE - ROLL_W;
  localparam logic [9:0] RSPD  = {6'd0, ROLL_SPEED};
  localparam logic [8:0] FSPD  = {5'd0, FALL_SPEED};

  state_t     state;
  dir_t       dir;
  logic [9:0] posx;
  logic [8:0] posy;
  logic [8:0] fall_cnt;
  logic       active;
  logic       done;

  logic       step;
  logic       at_edge;
  logic       on_floor;
  logic [8:0] new_fall;
  logic       landing;
  logic       trans;
  logic       anim_load;
  logic [2:0] anim_frame;
  logic       anim_step;

  // Step qualification and edge/landing detection.
  always_comb begin
    step = bus.frame_tick && !bus.pause &&
           (state == S_ROLL || state == S_FALL);
    if (dir == DIR_RIGHT)
      at_edge = (posx + RSPD) >= R_LIM;
    else
      at_edge = (posx - RSPD) <= LEFT_EDGE;
    on_floor  = posy >= FLOOR_Y;
    new_fall  = fall_cnt + FSPD;
    landing   = new_fall == PLAT_PITCH;
    trans     = (state == S_ROLL && at_edge) ||
                (state == S_FALL && landing);
    anim_load  = 1'b0;
    anim_frame = BARREL_ROLL1;
    unique case (1'b1)
      (state == S_IDLE && bus.spawn): begin
        anim_load  = 1'b1;
        anim_frame = BARREL_ROLL1;
      end
      (step && !bus.hit && state == S_ROLL &&
       at_edge && !on_floor): begin
        anim_load  = 1'b1;
        anim_frame = BARREL_FALL1;
      end
      (step && !bus.hit && state == S_FALL &&
       landing): begin
        anim_load  = 1'b1;
        anim_frame = (dir == DIR_LEFT)
                     ? BARREL_ROLL1 : BARREL_ROLL4;
      end
      default: ;
    endcase
    anim_step = step && !bus.hit && !trans;
  end

  // Position and state sequencing; hit wins over a tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      dir      <= DIR_RIGHT;
      posx     <= START_X;
      posy     <= START_Y;
      fall_cnt <= '0;
      active   <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.spawn) begin
            posx   <= START_X;
            posy   <= START_Y;
            dir    <= DIR_RIGHT;
            active <= 1'b1;
            state  <= S_ROLL;
          end
        end
        S_ROLL: begin
          if (bus.hit) begin
            active <= 1'b0;
            state  <= S_IDLE;
          end else if (step) begin
            if (at_edge) begin
              if (on_floor) begin
                posx  <= (dir == DIR_RIGHT)
                         ? R_LIM : LEFT_EDGE;
                state <= S_EXIT;
              end else begin
                posx <= ((dir == DIR_RIGHT)
                         ? R_LIM : LEFT_EDGE) - FALL_XOFF;
                fall_cnt <= '0;
                state    <= S_FALL;
              end
            end else if (dir == DIR_RIGHT) begin
              posx <= posx + RSPD;
            end else begin
              posx <= posx - RSPD;
            end
          end
        end
        S_FALL: begin
          if (bus.hit) begin
            active <= 1'b0;
            state  <= S_IDLE;
          end else if (step) begin
            posy     <= posy + FSPD;
            fall_cnt <= new_fall;
            if (landing) begin
              posx  <= posx + FALL_XOFF;
              dir   <= (dir == DIR_RIGHT)
                       ? DIR_LEFT : DIR_RIGHT;
              state <= S_ROLL;
            end
          end
        end
        S_EXIT: begin
          done   <= 1'b1;
          active <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  barrel_anim_seq #(
    .ANIM_DIV (ANIM_DIV)
  ) u_anim (
    .clk        (clk),
    .rst_n      (rst_n),
    .step       (anim_step),
    .mode_fall  (state == S_FALL),
    .dir        (dir),
    .load       (anim_load),
    .load_frame (anim_frame),
    .frame      (bus.animate_state)
  );

  assign bus.posx   = posx;
  assign bus.posy   = posy;
  assign bus.active = active;
  assign bus.done   = done;

endmodule

// File: tb/tb_barrel_ctrl.sv
// Directed bench for barrel_ctrl.
// Default parameters; expected values hand-derived.
module tb_barrel_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   done_cnt;

  barrel_if bif ();

  barrel_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk)
    if (bif.done === 1'b1) done_cnt++;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) bif.frame_tick = 1'b1;
      @(negedge clk) bif.frame_tick = 1'b0;
    end
  endtask

  task automatic do_spawn();
    @(negedge clk) bif.spawn = 1'b1;
    @(negedge clk) bif.spawn = 1'b0;
  endtask

  task automatic chk_pos(
    input string      nm,
    input logic [9:0] ex,
    input logic [8:0] ey,
    input logic [2:0] ea
  );
    checks++;
    if (bif.posx !== ex || bif.posy !== ey ||
        bif.animate_state !== ea) begin
      errors++;
      $display("FAIL %s: got x=%0d y=%0d a=%b want x=%0d y=%0d a=%b",
               nm, bif.posx, bif.posy, bif.animate_state,
               ex, ey, ea);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (bif.posx !== 10'd40 || bif.posy !== 9'd80 ||
        bif.animate_state !== 3'b000 ||
        bif.active !== 1'b0 || bif.done !== 1'b0) begin
      errors++;
      $display("FAIL reset: x=%0d y=%0d a=%b act=%b done=%b",
               bif.posx, bif.posy, bif.animate_state,
               bif.active, bif.done);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_spawn();
    do_spawn();
    tick(1);
    chk_pos("spawn_tick1", 10'd42, 9'd80, 3'b000);
    checks++;
    if (bif.active !== 1'b1) begin
      errors++;
      $display("FAIL spawn_active: got %b want 1", bif.active);
    end
    tick(3);
    chk_pos("spawn_tick4", 10'd48, 9'd80, 3'b001);
  endtask

  task automatic test_right_edge();
    tick(259);
    chk_pos("before_edge", 10'd566, 9'd80, 3'b001);
    tick(1);
    chk_pos("edge_fall", 10'd563, 9'd80, 3'b100);
  endtask

  task automatic test_fall();
    tick(4);
    chk_pos("fall4", 10'd563, 9'd96, 3'b101);
    tick(4);
    chk_pos("fall8", 10'd563, 9'd112, 3'b100);
    tick(8);
    chk_pos("land", 10'd568, 9'd144, 3'b011);
  endtask

  task automatic test_left_roll();
    tick(4);
    chk_pos("left4", 10'd560, 9'd144, 3'b010);
    tick(4);
    chk_pos("left8", 10'd552, 9'd144, 3'b001);
    tick(4);
    chk_pos("left12", 10'd544, 9'd144, 3'b000);
  endtask

  task automatic test_pause();
    bif.pause = 1'b1;
    tick(10);
    chk_pos("pause", 10'd544, 9'd144, 3'b000);
    bif.pause = 1'b0;
  endtask

  task automatic test_spawn_ignored();
    do_spawn();
    chk_pos("spawn_ign", 10'd544, 9'd144, 3'b000);
  endtask

  task automatic test_hit();
    done_cnt = 0;
    @(negedge clk) begin
      bif.frame_tick = 1'b1;
      bif.hit = 1'b1;
    end
    @(negedge clk) begin
      bif.frame_tick = 1'b0;
      bif.hit = 1'b0;
    end
    chk_pos("hit_pos", 10'd544, 9'd144, 3'b000);
    checks++;
    if (bif.active !== 1'b0) begin
      errors++;
      $display("FAIL hit_active: got %b want 0", bif.active);
    end
    tick(2);
    checks++;
    if (done_cnt !== 0) begin
      errors++;
      $display("FAIL hit_done: got %0d pulses want 0", done_cnt);
    end
  endtask

  task automatic test_floor_exit();
    int n;
    do_spawn();
    chk_pos("respawn", 10'd40, 9'd80, 3'b000);
    done_cnt = 0;
    n = 0;
    while (bif.active === 1'b1 && n < 3000) begin
      tick(1);
      n++;
    end
    tick(2);
    checks++;
    if (n !== 2017) begin
      errors++;
      $display("FAIL exit_ticks: got %0d want 2017", n);
    end
    checks++;
    if (done_cnt !== 1 || bif.active !== 1'b0) begin
      errors++;
      $display("FAIL exit_done: got %0d pulses act=%b want 1 act=0",
               done_cnt, bif.active);
    end
    checks++;
    if (bif.posx !== 10'd568 || bif.posy !== 9'd464) begin
      errors++;
      $display("FAIL exit_pos: got x=%0d y=%0d want 568 464",
               bif.posx, bif.posy);
    end
    do_spawn();
    chk_pos("restart", 10'd40, 9'd80, 3'b000);
  endtask

  task automatic test_reset_mid_fall();
    tick(266);
    chk_pos("mid_fall", 10'd563, 9'd88, 3'b100);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk_pos("async_rst", 10'd40, 9'd80, 3'b000);
    checks++;
    if (bif.active !== 1'b0 || bif.done !== 1'b0) begin
      errors++;
      $display("FAIL async_rst_flags: act=%b done=%b want 0 0",
               bif.active, bif.done);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    done_cnt = 0;
    bif.frame_tick = 1'b0;
    bif.spawn = 1'b0;
    bif.hit = 1'b0;
    bif.pause = 1'b0;
    test_reset();
    test_spawn();
    test_right_edge();
    test_fall();
    test_left_roll();
    test_pause();
    test_spawn_ignored();
    test_hit();
    test_floor_exit();
    test_reset_mid_fall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
